// File: rtl/dds_nco_multich.sv
// Multi-channel NCO: per-channel phase accumulators swept round-robin on each
// tick through a shared quarter-wave folded sine lookup (3-cycle latency).
module dds_nco_multich #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned ACC_W     = 24,
   parameter int unsigned CH_CT     = 4,
   parameter int unsigned CH_BITS   = 2,
   parameter string       MEM_FILE  = "sin_qtable_64x16.mem"
) (
   input  logic                     dds_clk,
   input  logic                     dds_rst_n,
   input  logic                     dds_ce,
   input  logic                     tick,
   input  logic                     ftw_we,
   input  logic [CH_BITS-1:0]       ftw_ch,
   input  logic [ACC_W-1:0]         ftw_data,
   input  logic                     phase_clr,
   output logic                     busy,
   output logic                     overrun,
   output logic                     out_valid,
   output logic [CH_BITS-1:0]       out_ch,
   output logic signed [DATA_W-1:0] out_sample
);

   localparam int unsigned SUB_W = ADDR_BITS - 2;
   localparam int unsigned TBL_N = 1 << SUB_W;

   if (MEM_FILE == "" || ACC_W < ADDR_BITS || CH_CT > (1 << CH_BITS)) begin : g_bad_cfg
      $error("dds_nco_multich: inconsistent parameters");
   end

   // Quarter-wave entry k = round(A*sin(2*pi*(k+0.5)/2^ADDR_BITS)), the same
   // contents as MEM_FILE, evaluated at elaboration in Q30 fixed point.
   function automatic logic [DATA_W-1:0] qsin(input int unsigned k);
      longint x, x2, term, sum;
      x    = (64'sd3373259426 * longint'(2 * k + 1)) >>> ADDR_BITS;
      x2   = (x * x + 64'sd536870912) >>> 30;
      term = x;
      sum  = x;
      for (int unsigned i = 1; i <= 10; i++) begin
         term = ((term * x2 + 64'sd536870912) >>> 30) / longint'(4 * i * i + 2 * i);
         sum  = ((i % 2) == 1) ? sum - term : sum + term;
      end
      return DATA_W'((((longint'(1) <<< (DATA_W - 1)) - 1) * sum + 64'sd536870912) >>> 30);
   endfunction

   logic [DATA_W-1:0] qtable [TBL_N];
   for (genvar k = 0; k < TBL_N; k++) begin : g_tbl
      localparam logic [DATA_W-1:0] ENTRY = qsin(k);
      assign qtable[k] = ENTRY;
   end

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t               state;
   logic [CH_BITS-1:0]   ch_idx;
   logic [ACC_W-1:0]     acc [CH_CT];
   logic [ACC_W-1:0]     ftw [CH_CT];
   logic [ADDR_BITS-1:0] idx;

   logic                 s1_valid, s1_neg;
   logic [CH_BITS-1:0]   s1_ch;
   logic [SUB_W-1:0]     s1_addr;
   logic                 s2_valid, s2_neg;
   logic [CH_BITS-1:0]   s2_ch;
   logic signed [DATA_W-1:0] rom_q;
   logic                 out_valid_q;

   assign idx       = acc[ch_idx][ACC_W-1 -: ADDR_BITS];
   assign busy      = (state == SWEEP);
   assign out_valid = out_valid_q & dds_ce;

   always_ff @(posedge dds_clk or negedge dds_rst_n) begin
      if (!dds_rst_n) begin
         state    <= IDLE;
         ch_idx   <= '0;
         overrun  <= 1'b0;
         s1_valid <= 1'b0;
         s1_neg   <= 1'b0;
         s1_ch    <= '0;
         s1_addr  <= '0;
         for (int unsigned c = 0; c < CH_CT; c++) begin
            acc[c] <= '0;
            ftw[c] <= '0;
         end
      end else if (dds_ce) begin
         overrun  <= 1'b0;
         s1_valid <= 1'b0;
         if (ftw_we) ftw[ftw_ch] <= ftw_data;
         case (state)
            IDLE: begin
               if (tick) begin
                  state  <= SWEEP;
                  ch_idx <= '0;
               end
            end
            SWEEP: begin
               overrun     <= tick;
               s1_valid    <= 1'b1;
               s1_ch       <= ch_idx;
               s1_neg      <= idx[ADDR_BITS-1];
               s1_addr     <= idx[ADDR_BITS-2] ? ~idx[SUB_W-1:0] : idx[SUB_W-1:0];
               acc[ch_idx] <= acc[ch_idx] + ftw[ch_idx];
               ch_idx      <= ch_idx + 1'b1;
               if (ch_idx == CH_BITS'(CH_CT - 1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Clear wins over the increment issued on the same edge.
         if (phase_clr) begin
            for (int unsigned c = 0; c < CH_CT; c++) acc[c] <= '0;
         end
      end
   end

   always_ff @(posedge dds_clk) begin
      if (dds_ce) rom_q <= qtable[s1_addr];
   end

   always_ff @(posedge dds_clk or negedge dds_rst_n) begin
      if (!dds_rst_n) begin
         s2_valid    <= 1'b0;
         s2_neg      <= 1'b0;
         s2_ch       <= '0;
         out_valid_q <= 1'b0;
         out_ch      <= '0;
         out_sample  <= '0;
      end else if (dds_ce) begin
         s2_valid    <= s1_valid;
         s2_neg      <= s1_neg;
         s2_ch       <= s1_ch;
         out_valid_q <= s2_valid;
         if (s2_valid) begin
            out_ch     <= s2_ch;
            out_sample <= s2_neg ? -rom_q : rom_q;
         end
      end
   end

endmodule

// File: tb/tb_dds_nco_multich.sv
// Bench for dds_nco_multich: directed hazard steps plus random stimulus, checked
// against an edge-indexed model using the full-wave sine formula.
module tb_dds_nco_multich;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned ADDR_BITS = 8;
   localparam int unsigned ACC_W     = 24;
   localparam int unsigned CH_CT     = 4;
   localparam int unsigned CH_BITS   = 2;
   localparam real         PI        = 3.14159265358979323846;
   localparam real         AMP       = 32767.0;

   logic                     dds_clk, dds_rst_n, dds_ce, tick, ftw_we, phase_clr;
   logic [CH_BITS-1:0]       ftw_ch;
   logic [ACC_W-1:0]         ftw_data;
   logic                     busy, overrun, out_valid;
   logic [CH_BITS-1:0]       out_ch;
   logic signed [DATA_W-1:0] out_sample;

   dds_nco_multich #(
      .DATA_W(DATA_W), .ADDR_BITS(ADDR_BITS), .ACC_W(ACC_W),
      .CH_CT(CH_CT), .CH_BITS(CH_BITS), .MEM_FILE("sin_qtable_64x16.mem")
   ) dut (
      .dds_clk(dds_clk), .dds_rst_n(dds_rst_n), .dds_ce(dds_ce), .tick(tick),
      .ftw_we(ftw_we), .ftw_ch(ftw_ch), .ftw_data(ftw_data), .phase_clr(phase_clr),
      .busy(busy), .overrun(overrun), .out_valid(out_valid), .out_ch(out_ch),
      .out_sample(out_sample)
   );

   always #5 dds_clk = ~dds_clk;

   typedef struct {
      int                       e;
      int                       ch;
      logic signed [DATA_W-1:0] smp;
   } exp_t;

   exp_t           expq[$];
   logic [ACC_W-1:0] m_acc [CH_CT];
   logic [ACC_W-1:0] m_ftw [CH_CT];
   int             en_e, sw_s;
   bit             sw_on, exp_busy, exp_ovr;
   int             checks, failures;

   function automatic logic signed [DATA_W-1:0] golden(input int unsigned phase_idx);
      real v;
      int  r;
      v = AMP * $sin(2.0 * PI * (real'(phase_idx) + 0.5) / real'(1 << ADDR_BITS));
      r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      return DATA_W'(r);
   endfunction

   // Tick accepted at enabled edge s issues channel k at edge s+1+k; its sample appears after edge s+3+k.
   task automatic model_edge(input bit t, input bit we, input int unsigned ch,
                             input logic [ACC_W-1:0] d, input bit clr);
      bit in_sweep;
      int k;
      en_e++;
      in_sweep = sw_on && (en_e >= sw_s + 1) && (en_e <= sw_s + int'(CH_CT));
      if (in_sweep) begin
         k = en_e - sw_s - 1;
         expq.push_back('{en_e + 2, k, golden(32'(m_acc[k] >> (ACC_W - ADDR_BITS)))});
         m_acc[k] = m_acc[k] + m_ftw[k];
      end
      if (clr) foreach (m_acc[c]) m_acc[c] = '0;
      if (we) m_ftw[ch] = d;
      exp_ovr = t && in_sweep;
      if (t && !in_sweep) begin
         sw_on = 1'b1;
         sw_s  = en_e;
      end
      exp_busy = sw_on && (en_e >= sw_s) && (en_e < sw_s + int'(CH_CT));
   endtask

   task automatic check_outputs();
      bit ev;
      ev = (expq.size() > 0) && (expq[0].e == en_e) && (dds_ce == 1'b1);
      checks++;
      assert (busy === exp_busy) else begin
         failures++; $error("FAIL busy edge=%0d: got %b want %b", en_e, busy, exp_busy);
      end
      checks++;
      assert (overrun === exp_ovr) else begin
         failures++; $error("FAIL overrun edge=%0d: got %b want %b", en_e, overrun, exp_ovr);
      end
      checks++;
      assert (out_valid === ev) else begin
         failures++; $error("FAIL out_valid edge=%0d: got %b want %b", en_e, out_valid, ev);
      end
      if (ev) begin
         checks++;
         assert (out_ch === CH_BITS'(expq[0].ch)) else begin
            failures++; $error("FAIL out_ch edge=%0d: got %0d want %0d", en_e, out_ch, expq[0].ch);
         end
         checks++;
         assert (out_sample === expq[0].smp) else begin
            failures++;
            $error("FAIL out_sample edge=%0d ch=%0d: got %0d want %0d", en_e, expq[0].ch, out_sample, expq[0].smp);
         end
         void'(expq.pop_front());
      end
   endtask

   task automatic step(input bit t = 1'b0, input bit we = 1'b0, input int unsigned ch = 0,
                       input logic [ACC_W-1:0] d = '0, input bit clr = 1'b0, input bit ce = 1'b1);
      tick      = t;
      ftw_we    = we;
      ftw_ch    = CH_BITS'(ch);
      ftw_data  = d;
      phase_clr = clr;
      dds_ce    = ce;
      @(posedge dds_clk);
      if (ce) model_edge(t, we, ch, d, clr);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      tick = 1'b0; ftw_we = 1'b0; phase_clr = 1'b0; dds_ce = 1'b1;
      dds_rst_n = 1'b0;
      #1;
      checks++;
      assert (out_valid === 1'b0) else begin failures++; $error("FAIL rst out_valid: got %b want 0", out_valid); end
      checks++;
      assert (busy === 1'b0) else begin failures++; $error("FAIL rst busy: got %b want 0", busy); end
      checks++;
      assert (overrun === 1'b0) else begin failures++; $error("FAIL rst overrun: got %b want 0", overrun); end
      checks++;
      assert (out_sample === '0) else begin failures++; $error("FAIL rst out_sample: got %0d want 0", out_sample); end
      checks++;
      assert (out_ch === '0) else begin failures++; $error("FAIL rst out_ch: got %0d want 0", out_ch); end
      expq.delete();
      foreach (m_acc[c]) begin
         m_acc[c] = '0;
         m_ftw[c] = '0;
      end
      sw_on = 1'b0; exp_busy = 1'b0; exp_ovr = 1'b0;
      @(posedge dds_clk);
      @(posedge dds_clk);
      #2;
      dds_rst_n = 1'b1;
   endtask

   initial begin
      dds_clk = 1'b0; dds_rst_n = 1'b1; dds_ce = 1'b1; tick = 1'b0; ftw_we = 1'b0;
      ftw_ch = '0; ftw_data = '0; phase_clr = 1'b0;
      checks = 0; failures = 0; en_e = 0; sw_s = 0;
      #3;
      do_reset();

      // All FTWs zero: four samples of the phase-0 entry, busy for four cycles.
      step(1'b1);
      idle(8);

      // Full wave on ch0 (index steps by 1 per tick), half-wave flip on ch1.
      step(1'b0, 1'b1, 0, 24'h010000);
      step(1'b0, 1'b1, 1, 24'h800000);
      for (int unsigned n = 0; n < 256; n++) begin
         step(1'b1);
         idle(4);
      end
      idle(4);

      // FTW write to ch2 on its own issue edge: old FTW used this sweep.
      step(1'b1);
      idle(2);
      step(1'b0, 1'b1, 2, 24'h123456);
      idle(4);
      step(1'b1); idle(5);
      step(1'b1); idle(7);

      // phase_clr on ch3's issue edge, then on a mid-sweep edge.
      step(1'b0, 1'b1, 3, 24'h0ABCDE);
      step(1'b1); idle(3);
      step(1'b0, 1'b0, 0, '0, 1'b1);
      idle(3);
      step(1'b1); idle(7);
      step(1'b1); idle(1);
      step(1'b0, 1'b0, 0, '0, 1'b1);
      idle(6);
      step(1'b1); idle(7);

      // Ticks while busy, including the final sweep cycle, then back-to-back.
      step(1'b1); step(); step(1'b1); step(); step(1'b1); step(1'b1);
      idle(9);

      // Clock enable gap of five cycles mid-sweep.
      step(1'b1); idle(2);
      for (int unsigned i = 0; i < 5; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
      idle(8);

      for (int unsigned i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, CH_CT - 1),
              ACC_W'($urandom), $urandom_range(0, 29) == 0, $urandom_range(0, 7) != 0);
      end
      idle(8);

      // Reset mid-sweep discards in-flight samples; nothing appears afterwards.
      step(1'b1); idle(2);
      do_reset();
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
